// File: rtl/juego_pkg.sv
// juego_pkg: shared state encoding, note codes and LFSR taps for the note-memory game
package juego_pkg;

    typedef enum logic [2:0] {IDLE, GEN, MOSTRAR, PAUSA, ESPERA, ECO, GANAR, PERDER} estado_t;

    localparam logic [2:0] NOTA_NINGUNA  = 3'd0;
    localparam logic [2:0] NOTA_MANO_IZQ = 3'd1;
    localparam logic [2:0] NOTA_MANO_DER = 3'd2;
    localparam logic [2:0] NOTA_CABEZA   = 3'd3;
    localparam logic [2:0] NOTA_PIES     = 3'd4;

    // Fibonacci taps 8,6,5,4 (bit 7 is tap 8)
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR with step enable; also exposes the low bits of the next state
module lfsr8
    import juego_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       paso,
    output logic [7:0] estado,
    output logic [1:0] nota
);

    logic [7:0] siguiente;

    assign siguiente = {estado[6:0], ^(estado & LFSR_TAPS)};
    assign nota      = siguiente[1:0];

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n)
            estado <= SEED;
        else if (paso)
            estado <= siguiente;
    end

endmodule

// File: rtl/secuenciador_notas.sv
// secuenciador_notas: note-memory game controller (generate, play back, check presses, win/lose).
// Define JUEGO_TIMEOUT_EN to lose when the player waits TICKS_TIMEOUT cycles without pressing.
module secuenciador_notas
    import juego_pkg::*;
#(
    parameter int         TICKS_NOTA    = 12500000,
    parameter int         TICKS_PAUSA   = 6250000,
    parameter int         TICKS_TIMEOUT = 75000000,
    parameter int         MAX_NIVEL     = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       start,
    input  logic [3:0] boton,
    output logic [2:0] activacion_nota,
    output logic       modo_activo,
    output logic       modo_ganar,
    output logic       modo_perder,
    output logic [3:0] nivel
);

    localparam int TW = $clog2(max3(TICKS_NOTA, TICKS_PAUSA, TICKS_TIMEOUT));
    localparam logic [TW-1:0] FIN_NOTA    = TW'(TICKS_NOTA - 1);
    localparam logic [TW-1:0] FIN_PAUSA   = TW'(TICKS_PAUSA - 1);
`ifdef JUEGO_TIMEOUT_EN
    localparam logic [TW-1:0] FIN_TIMEOUT = TW'(TICKS_TIMEOUT - 1);
`endif
    localparam logic [3:0] NIVEL_MAX = 4'(MAX_NIVEL);
    localparam logic [3:0] ULT_GEN   = 4'(MAX_NIVEL - 1);

    estado_t       state, state_n;
    logic [3:0]    idx, idx_n, nivel_n, boton_q, pulsos;
    logic [TW-1:0] timer, timer_n;
    logic          pre, pre_n, paso;
    logic [1:0]    nota_gen;
    logic [7:0]    lfsr_unused;
    logic [1:0]    seq [16];

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .dclk   (dclk),
        .clr_n  (clr_n),
        .paso   (paso),
        .estado (lfsr_unused),
        .nota   (nota_gen)
    );

    assign pulsos = boton & ~boton_q;

    always_ff @(posedge dclk) begin
        if (state == GEN)
            seq[idx] <= nota_gen;
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        nivel_n = nivel;
        pre_n   = pre;
        timer_n = timer + TW'(1);
        paso    = 1'b0;
        case (state)
            IDLE, GANAR, PERDER:
                if (start) begin
                    state_n = GEN;
                    idx_n   = '0;
                    nivel_n = '0;
                    pre_n   = 1'b0;
                end
            GEN: begin
                paso  = 1'b1;
                idx_n = idx + 4'd1;
                if (idx == ULT_GEN) begin
                    state_n = MOSTRAR;
                    idx_n   = '0;
                    nivel_n = 4'd1;
                end
            end
            MOSTRAR:
                if (timer == FIN_NOTA)
                    state_n = PAUSA;
            PAUSA:
                if (timer == FIN_PAUSA) begin
                    // pre marks the gap that precedes a replay from the first note
                    if (pre) begin
                        pre_n   = 1'b0;
                        state_n = MOSTRAR;
                    end else if (idx < nivel - 4'd1) begin
                        idx_n   = idx + 4'd1;
                        state_n = MOSTRAR;
                    end else begin
                        idx_n   = '0;
                        state_n = ESPERA;
                    end
                end
            ESPERA: begin
`ifdef JUEGO_TIMEOUT_EN
                if (timer == FIN_TIMEOUT)
                    state_n = PERDER;
`else
                timer_n = timer;
`endif
                if (|pulsos)
                    state_n = (pulsos == (4'b0001 << seq[idx])) ? ECO : PERDER;
            end
            ECO:
                if (timer == FIN_PAUSA) begin
                    if (idx < nivel - 4'd1) begin
                        idx_n   = idx + 4'd1;
                        state_n = ESPERA;
                    end else if (nivel == NIVEL_MAX) begin
                        state_n = GANAR;
                    end else begin
                        nivel_n = nivel + 4'd1;
                        idx_n   = '0;
                        pre_n   = 1'b1;
                        state_n = PAUSA;
                    end
                end
        endcase
        if (state_n != state)
            timer_n = '0;
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state           <= IDLE;
            idx             <= '0;
            timer           <= '0;
            pre             <= 1'b0;
            boton_q         <= '0;
            nivel           <= '0;
            activacion_nota <= NOTA_NINGUNA;
            modo_activo     <= 1'b0;
            modo_ganar      <= 1'b0;
            modo_perder     <= 1'b0;
        end else begin
            state           <= state_n;
            idx             <= idx_n;
            timer           <= timer_n;
            pre             <= pre_n;
            boton_q         <= boton;
            nivel           <= nivel_n;
            activacion_nota <= (state_n == MOSTRAR || state_n == ECO) ? NOTA_MANO_IZQ + {1'b0, seq[idx_n]} : NOTA_NINGUNA;
            modo_activo     <= state_n != IDLE;
            modo_ganar      <= state_n == GANAR;
            modo_perder     <= state_n == PERDER;
        end
    end

endmodule
